// File: rtl/irq_ctrl_if.sv
// Core load/store bus as seen by a memory-mapped peripheral.
// Ports: addr/wr/din driven by the core (master), dout returned by the peripheral (slave).
interface irq_ctrl_if;
  logic [15:0] addr;
  logic        wr;
  logic [15:0] din;
  logic [15:0] dout;

  modport master (
    output addr,
    output wr,
    output din,
    input  dout
  );

  modport slave (
    input  addr,
    input  wr,
    input  din,
    output dout
  );
endinterface

// File: rtl/irq_ctrl.sv
// Interrupt controller: PEND/ENABLE/CLAIM/EOI at BASE_ADDR..+3, drives irq/irq_id.
// Ports: clk, rst (sync high), bus (irq_ctrl_if.slave), src, irq, irq_id. Macro: IRQ_CTRL_LEVEL_EN.
module irq_ctrl #(
  parameter int          NUM_SRC   = 8,
  parameter logic [15:0] BASE_ADDR = 16'hFFF0
) (
  input  logic               clk,
  input  logic               rst,
  irq_ctrl_if.slave          bus,
  input  logic [NUM_SRC-1:0] src,
  output logic               irq,
  output logic [7:0]         irq_id
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_SVC  = 2'd2;

  localparam logic [1:0] R_PEND  = 2'd0;
  localparam logic [1:0] R_EN    = 2'd1;
  localparam logic [1:0] R_CLAIM = 2'd2;
  localparam logic [1:0] R_EOI   = 2'd3;

  logic [1:0]         state;
  logic [NUM_SRC-1:0] pend;
  logic [NUM_SRC-1:0] en;
  logic [NUM_SRC-1:0] pend_nxt;
  logic [NUM_SRC-1:0] req;
  logic [NUM_SRC-1:0] id_oh;
  logic [7:0]         win;
  logic [15:0]        off;
  logic               hit;
  logic [1:0]         sel;
  logic               pend_wr;
  logic               en_wr;
  logic               claim_wr;
  logic               eoi_wr;
  logic               live;
  logic               in_svc;

  // Upper data bits are never stored
  wire unused_din = ^bus.din;

  // Address decode: offset wraps, so anything below BASE_ADDR misses too
  assign off = bus.addr - BASE_ADDR;
  assign hit = (off[15:2] == 14'd0);
  assign sel = off[1:0];

  assign pend_wr  = bus.wr && hit && (sel == R_PEND);
  assign en_wr    = bus.wr && hit && (sel == R_EN);
  assign claim_wr = bus.wr && hit && (sel == R_CLAIM);
  assign eoi_wr   = bus.wr && hit && (sel == R_EOI);

  assign in_svc = (state == S_SVC);
  assign req    = pend & en;

  // Lowest index wins
  always_comb begin
    win = 8'd0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (req[i]) win = 8'(i);
    end
  end

  always_comb begin
    id_oh = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      id_oh[i] = (irq_id == 8'(i));
    end
  end

`ifdef IRQ_CTRL_LEVEL_EN
  // Level mode: pending mirrors the sources, clears have no effect
  assign pend_nxt = src;
`else
  logic [NUM_SRC-1:0] src_q;
  logic [NUM_SRC-1:0] set_v;
  logic [NUM_SRC-1:0] clr_v;
  logic [NUM_SRC-1:0] claim_m;

  always_ff @(posedge clk) begin
    if (rst) src_q <= '0;
    else     src_q <= src;
  end

  assign set_v   = src & ~src_q;
  assign claim_m = (claim_wr && state == S_REQ) ? id_oh : '0;

  always_comb begin
    clr_v = claim_m;
    if (pend_wr) clr_v = clr_v | bus.din[NUM_SRC-1:0];
  end

  // Set wins over a same-cycle clear
  assign pend_nxt = (pend & ~clr_v) | set_v;
`endif

  // Request is withdrawn once its pending bit is going away;
  // enable is the value before any write in this cycle
  assign live = |(pend_nxt & en & id_oh);

  always_ff @(posedge clk) begin
    if (rst) begin
      pend   <= '0;
      en     <= '0;
      state  <= S_IDLE;
      irq    <= 1'b0;
      irq_id <= 8'd0;
    end else begin
      pend <= pend_nxt;
      if (en_wr) en <= bus.din[NUM_SRC-1:0];
      case (state)
        S_IDLE: begin
          if (|req) begin
            state  <= S_REQ;
            irq    <= 1'b1;
            irq_id <= win;
          end
        end
        S_REQ: begin
          if (claim_wr) begin
            state <= S_SVC;
            irq   <= 1'b0;
          end else if (!live) begin
            state <= S_IDLE;
            irq   <= 1'b0;
          end
        end
        S_SVC: begin
          if (eoi_wr) state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
          irq   <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    bus.dout = 16'h0000;
    if (hit) begin
      case (sel)
        R_PEND:  bus.dout = 16'(pend);
        R_EN:    bus.dout = 16'(en);
        R_CLAIM: bus.dout = {irq, in_svc, 6'b0, irq_id};
        R_EOI:   bus.dout = 16'h0000;
        default: bus.dout = 16'h0000;
      endcase
    end
  end

endmodule
